pe_seq_ctrl: RTL and testbench

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_seq_ctrl_pkg.sv | 29 ++
 rtl/pe_seq_be_gen.sv | 26 ++
 rtl/pe_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_ctrl_pkg.sv
// Shared definitions for the PE sequencer: arithmetic opcodes, sequencer states
// and the destination-element-width helper.
package pe_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        PE_ARITH_ADD = 3'd0,
        PE_ARITH_SUB = 3'd1,
        PE_ARITH_MUL = 3'd2,
        PE_ARITH_MAC = 3'd3,
        PE_ARITH_MIN = 3'd4,
        PE_ARITH_MAX = 3'd5
    } pe_arith_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_FINISH = 2'd2
    } pe_seq_state_t;

    // Destination element width code: source width plus widening shift.
    // The reserved widening code 3 behaves like "no widening".
    function automatic logic [2:0] calc_dsew(input logic [1:0] vsew,
                                             input logic [1:0] widening);
        logic [2:0] wshift;
        wshift = (widening == 2'd3) ? 3'd0 : {1'b0, widening};
        return {1'b0, vsew} + wshift;
    endfunction

endpackage

// File: rtl/pe_seq_be_gen.sv
// Destination byte-enable generator: enables the low (remaining << dsew) bytes,
// saturating to all ones when a full group remains. Purely combinational.
module pe_seq_be_gen
    import pe_seq_ctrl_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int VL_W   = 8
) (
    input  logic [VL_W-1:0]       remaining,
    input  logic [1:0]            dsew,
    output logic [NUM_PE*4-1:0]   be
);

    localparam int BW = VL_W + 2;

    logic [BW-1:0] bytes_left;

    assign bytes_left = {2'b00, remaining} << dsew;

    generate
        for (genvar gi = 0; gi < NUM_PE * 4; gi++) begin : g_be
            assign be[gi] = (bytes_left > BW'(gi));
        end
    endgenerate

endmodule

// File: rtl/pe_seq_ctrl.sv
// Vector sequencer for NUM_PE parallel 32b PE lanes: accepts one request,
// issues ceil(vl/EPG) element groups with byte enables, then pulses done.
module pe_seq_ctrl
    import pe_seq_ctrl_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int VL_W   = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  pe_arith_op_t          req_op,
    input  logic [1:0]            req_vsew,
    input  logic [1:0]            req_widening,
    input  logic [VL_W-1:0]       req_vl,
    input  logic                  stall,
    output logic                  pe_valid,
    output pe_arith_op_t          pe_op,
    output logic [1:0]            pe_vsew,
    output logic [1:0]            pe_widening,
    output logic [VL_W-1:0]       grp_idx,
    output logic [NUM_PE*4-1:0]   pe_be,
    output logic                  pe_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BYTES = NUM_PE * 4;

    pe_seq_state_t    state_reg,    state_next;
    pe_arith_op_t     op_reg,       op_next;
    logic [1:0]       vsew_reg,     vsew_next;
    logic [1:0]       widening_reg, widening_next;
    logic [1:0]       dsew_reg,     dsew_next;
    logic [VL_W-1:0]  rem_reg,      rem_next;
    logic [VL_W-1:0]  grp_reg,      grp_next;
    logic             err_reg,      err_next;

    logic [2:0]       req_dsew;
    logic             req_illegal;
    logic [VL_W:0]    epg;
    logic             last_grp;
    logic [BYTES-1:0] be_raw;

    assign req_dsew    = calc_dsew(req_vsew, req_widening);
    assign req_illegal = (req_vsew == 2'd3) || (req_dsew > 3'd2);

    // rem_reg tracks elements still to issue, so the last group is simply the
    // one where no more than one group's worth of elements remains.
    assign epg      = (VL_W + 1)'(BYTES) >> dsew_reg;
    assign last_grp = ({1'b0, rem_reg} <= epg);

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        vsew_next     = vsew_reg;
        widening_next = widening_reg;
        dsew_next     = dsew_reg;
        rem_next      = rem_reg;
        grp_next      = grp_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    op_next       = req_op;
                    vsew_next     = req_vsew;
                    widening_next = req_widening;
                    dsew_next     = req_illegal ? 2'd0 : req_dsew[1:0];
                    rem_next      = req_vl;
                    grp_next      = '0;
                    err_next      = req_illegal;
                    state_next    = (req_illegal || req_vl == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    if (last_grp) begin
                        state_next = ST_FINISH;
                    end else begin
                        grp_next = grp_reg + 1'b1;
                        rem_next = rem_reg - epg[VL_W-1:0];
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
                err_next   = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg    <= ST_IDLE;
            op_reg       <= PE_ARITH_ADD;
            vsew_reg     <= 2'd0;
            widening_reg <= 2'd0;
            dsew_reg     <= 2'd0;
            rem_reg      <= '0;
            grp_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            vsew_reg     <= vsew_next;
            widening_reg <= widening_next;
            dsew_reg     <= dsew_next;
            rem_reg      <= rem_next;
            grp_reg      <= grp_next;
            err_reg      <= err_next;
        end
    end

    pe_seq_be_gen #(
        .NUM_PE (NUM_PE),
        .VL_W   (VL_W)
    ) u_be_gen (
        .remaining (rem_reg),
        .dsew      (dsew_reg),
        .be        (be_raw)
    );

    assign req_ready   = (state_reg == ST_IDLE);
    assign busy        = (state_reg != ST_IDLE);
    assign pe_valid    = (state_reg == ST_ISSUE);
    assign pe_last     = pe_valid && last_grp;
    assign pe_be       = pe_valid ? be_raw : '0;
    assign done        = (state_reg == ST_FINISH);
    assign err         = done && err_reg;
    assign grp_idx     = grp_reg;
    assign pe_op       = op_reg;
    assign pe_vsew     = vsew_reg;
    assign pe_widening = widening_reg;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: hand-computed group sequences, byte enables,
// stall hold, vl=0, illegal widths and mid-flight reset.
module tb_pe_seq_ctrl;
    import pe_seq_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          req_valid;
    logic          req_ready;
    pe_arith_op_t  req_op;
    logic [1:0]    req_vsew;
    logic [1:0]    req_widening;
    logic [7:0]    req_vl;
    logic          stall;
    logic          pe_valid;
    pe_arith_op_t  pe_op;
    logic [1:0]    pe_vsew;
    logic [1:0]    pe_widening;
    logic [7:0]    grp_idx;
    logic [15:0]   pe_be;
    logic          pe_last;
    logic          busy;
    logic          done;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_seq_ctrl #(.NUM_PE(4), .VL_W(8)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_vsew     (req_vsew),
        .req_widening (req_widening),
        .req_vl       (req_vl),
        .stall        (stall),
        .pe_valid     (pe_valid),
        .pe_op        (pe_op),
        .pe_vsew      (pe_vsew),
        .pe_widening  (pe_widening),
        .grp_idx      (grp_idx),
        .pe_be        (pe_be),
        .pe_last      (pe_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input pe_arith_op_t op, input logic [1:0] vsew,
                        input logic [1:0] wid, input logic [7:0] vl);
        req_valid    = 1'b1;
        req_op       = op;
        req_vsew     = vsew;
        req_widening = wid;
        req_vl       = vl;
        tick();
        req_valid    = 1'b0;
    endtask

    int vcount;
    int bound;
    logic [7:0]  last_grp_seen;
    logic [15:0] last_be_seen;

    initial begin
        n_reset = 1'b0; req_valid = 1'b0; req_op = PE_ARITH_ADD;
        req_vsew = 2'd0; req_widening = 2'd0; req_vl = 8'd0; stall = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", pe_valid, 0);
        chk("rst_last", pe_last, 0);
        chk("rst_grp", grp_idx, 0);
        chk("rst_be", pe_be, 0);
        chk("rst_op", pe_op, PE_ARITH_ADD);
        chk("rst_vsew", pe_vsew, 0);
        chk("rst_wid", pe_widening, 0);
        n_reset = 1'b1;
        tick();

        // 8b, vl=40: EPG=16 -> groups 0,1,2, last be 0x00FF
        $display("txn1: op=MUL vsew=0 wid=0 vl=40");
        send(PE_ARITH_MUL, 2'd0, 2'd0, 8'd40);
        chk("t1_c1_valid", pe_valid, 1);
        chk("t1_c1_grp", grp_idx, 0);
        chk("t1_c1_be", pe_be, 16'hFFFF);
        chk("t1_c1_last", pe_last, 0);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_ready", req_ready, 0);
        chk("t1_op", pe_op, PE_ARITH_MUL);
        tick();
        chk("t1_c2_grp", grp_idx, 1);
        chk("t1_c2_be", pe_be, 16'hFFFF);
        tick();
        chk("t1_c3_grp", grp_idx, 2);
        chk("t1_c3_be", pe_be, 16'h00FF);
        chk("t1_c3_last", pe_last, 1);
        tick();
        chk("t1_c4_done", done, 1);
        chk("t1_c4_err", err, 0);
        chk("t1_c4_valid", pe_valid, 0);
        chk("t1_c4_be", pe_be, 0);
        chk("t1_c4_busy", busy, 1);
        tick();
        chk("t1_c5_done", done, 0);
        chk("t1_c5_ready", req_ready, 1);
        chk("t1_c5_busy", busy, 0);

        // 16b widened to 32b, vl=5: EPG=4 -> be 0xFFFF then 0x000F
        $display("txn2: op=SUB vsew=1 wid=1 vl=5");
        send(PE_ARITH_SUB, 2'd1, 2'd1, 8'd5);
        chk("t2_c1_grp", grp_idx, 0);
        chk("t2_c1_be", pe_be, 16'hFFFF);
        chk("t2_c1_last", pe_last, 0);
        chk("t2_vsew", pe_vsew, 1);
        chk("t2_wid", pe_widening, 1);
        tick();
        chk("t2_c2_grp", grp_idx, 1);
        chk("t2_c2_be", pe_be, 16'h000F);
        chk("t2_c2_last", pe_last, 1);
        tick();
        chk("t2_c3_done", done, 1);
        tick();

        // vl=0: straight to done, no issue
        $display("txn3: op=ADD vsew=0 wid=0 vl=0");
        send(PE_ARITH_ADD, 2'd0, 2'd0, 8'd0);
        chk("t3_valid", pe_valid, 0);
        chk("t3_done", done, 1);
        chk("t3_err", err, 0);
        tick();
        chk("t3_ready", req_ready, 1);
        chk("t3_done_end", done, 0);

        // 32b, vl=64: 16 groups, 3 stalled cycles at grp 1 -> 19 valid cycles
        $display("txn4: op=MAC vsew=2 wid=0 vl=64 stall x3 at grp 1");
        send(PE_ARITH_MAC, 2'd2, 2'd0, 8'd64);
        chk("t4_c1_grp", grp_idx, 0);
        vcount = 1;
        tick();
        chk("t4_c2_grp", grp_idx, 1);
        vcount++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_grp", grp_idx, 1);
            chk("t4_stall_valid", pe_valid, 1);
            vcount++;
        end
        stall = 1'b0;
        last_grp_seen = grp_idx;
        last_be_seen  = pe_be;
        bound = 0;
        while (bound < 40) begin
            tick();
            bound++;
            if (!pe_valid) break;
            vcount++;
            last_grp_seen = grp_idx;
            last_be_seen  = pe_be;
        end
        chk("t4_bound", (bound < 40) ? 1 : 0, 1);
        chk("t4_vcount", vcount, 19);
        chk("t4_last_grp", last_grp_seen, 15);
        chk("t4_last_be", last_be_seen, 16'hFFFF);
        chk("t4_done", done, 1);
        tick();

        // 32b source widened: illegal -> err with done, no issue
        $display("txn5: op=ADD vsew=2 wid=1 vl=8 (illegal)");
        send(PE_ARITH_ADD, 2'd2, 2'd1, 8'd8);
        chk("t5_valid", pe_valid, 0);
        chk("t5_err", err, 1);
        chk("t5_done", done, 1);
        tick();
        chk("t5_err_end", err, 0);
        chk("t5_ready", req_ready, 1);

        // Reset while grp_idx=2
        $display("txn6: op=MAX vsew=0 wid=0 vl=40 reset at grp 2");
        send(PE_ARITH_MAX, 2'd0, 2'd0, 8'd40);
        tick(); tick();
        chk("t6_grp_pre", grp_idx, 2);
        n_reset = 1'b0;
        tick();
        chk("t6_ready", req_ready, 1);
        chk("t6_valid", pe_valid, 0);
        chk("t6_done", done, 0);
        chk("t6_busy", busy, 0);
        n_reset = 1'b1;
        tick();
        chk("t6_done_after", done, 0);
        chk("t6_valid_after", pe_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
